cursor_matriz: RTL and testbench
================================

# cursor_matriz

Parametrised cursor-position controller for the board's LED/VGA matrix. Four direction buttons move a cursor inside a COLS x ROWS grid. Each button input passes through a synchroniser and a rising-edge detector. Outputs are the registered cursor coordinates and one-cycle move/blocked strobes for the display and game logic. Adds over the fixed 8x8 mover: generic grid size, optional wrap-around, home/centre command, deterministic reset of all state, and compile-time auto-repeat on held buttons.

## Interface
- COLS, 8, grid width in cells (>=2)
- ROWS, 8, grid height in cells (>=2)
- X_W, $clog2(COLS), pos_x width (derived, not overridden)
- Y_W, $clog2(ROWS), pos_y width (derived, not overridden)
- HOME_X, 0, reset/home column (<COLS)
- HOME_Y, 0, reset/home row (<ROWS)
- WRAP, 0, 1 = wrap at edges; 0 = saturate
- SYNC_STAGES, 2, synchroniser depth per button (>=2)
- REPEAT_DELAY, 25_000_000, hold cycles before first auto-repeat (repeat build only)
- REPEAT_RATE, 5_000_000, cycles between repeats (repeat build only)

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- arriba  in  1  raw button, up (pos_y+1); asynchronous to clk
- abajo  in  1  raw button, down (pos_y-1)
- derecha  in  1  raw button, right (pos_x+1)
- izquierda  in  1  raw button, left (pos_x-1)
- centrar  in  1  synchronous home request, level, already in clk domain
- pos_x  out  X_W  cursor column
- pos_y  out  Y_W  cursor row
- moved  out  1  one-cycle pulse, position changed this cycle
- blocked  out  1  one-cycle pulse, press rejected at edge (WRAP=0 only)

## Operation
- Reset (reset=0): pos_x=HOME_X, pos_y=HOME_Y, moved=0, blocked=0.
- Reset also clears synchroniser flops to 0 and sets edge-history flops to 1. A button held through reset release does not generate a move; it must be released and pressed again.
- A press is a 0->1 transition on the last synchroniser stage.
- Priority when several presses coincide: centrar > abajo > arriba > derecha > izquierda. Exactly one action per cycle. Lower-priority presses in that cycle are discarded, not queued.
- centrar=1: load HOME_X/HOME_Y. moved=1 only if the position differs from home.
- Move at edge:
  - WRAP=0: position unchanged, blocked=1, moved=0.
  - WRAP=1: abajo at 0 -> ROWS-1; arriba at ROWS-1 -> 0; derecha at COLS-1 -> 0; izquierda at 0 -> COLS-1. moved=1.
- Non-power-of-two grids never expose a coordinate >= COLS/ROWS.
- The edge-history flops update every cycle, regardless of priority outcome.

## Timing
- Raw input first sampled high at edge N -> pos/moved update at edge N+SYNC_STAGES.
- centrar sampled at edge N -> update at edge N (registered, no synchroniser).
- moved and blocked are high for exactly one cycle per action and are never both high.
- Asynchronous reset mid-hold or mid-repeat aborts all activity immediately.

## Configuration
- Macro CURSOR_REPEAT_EN, auto-repeat FSM.
- Defined: FSM with states IDLE, HOLD and REPEAT.
  - IDLE -> HOLD on an accepted direction press. The first move happens at the press; the counter loads REPEAT_DELAY-1.
  - HOLD -> REPEAT on counter 0 while the same synchronised button is still high. Generates a repeat move; the counter loads REPEAT_RATE-1.
  - REPEAT stays in REPEAT, issuing one move every REPEAT_RATE cycles.
  - Release of the tracked button, centrar, or a new press on another button returns the FSM to IDLE. A new press is then processed as a fresh press that same cycle.
  - Repeat moves obey WRAP/blocked rules. Each blocked repeat pulses blocked.
- Undefined: no FSM and no counter. Exactly one move per press; REPEAT_* parameters are unused.

## Test plan
- Reset release with all buttons low, HOME_X=3, HOME_Y=5 -> pos=(3,5), moved=0, blocked=0. Then one derecha press -> pos=(4,5) at edge N+2, moved high one cycle.
- COLS=5, WRAP=0, pos_x=4, derecha press -> pos_x stays 4, blocked=1 for one cycle. Repeat with WRAP=1 -> pos_x=0, moved=1.
- abajo and derecha rise on the same edge from (2,2) -> (2,1) only. derecha held, so no later move.
- Button held through reset deassertion -> no move. Release then press -> exactly one move.
- With CURSOR_REPEAT_EN, REPEAT_DELAY=10, REPEAT_RATE=3: arriba held 20 cycles from (0,0) -> moves at press+0, +10, +13, +16, +19; pos_y=5. Without the macro -> pos_y=1.
- Mid-repeat reset assert -> pos=home, FSM IDLE. centrar during hold -> home and repeat stops.

Source files
------------

// File: rtl/cursor_matriz.sv
// Cursor-position controller for a COLS x ROWS LED/VGA matrix driven by four asynchronous buttons.
// Define CURSOR_REPEAT_EN to build the hold-to-repeat FSM (IDLE/HOLD/REPEAT); otherwise one move per press.

module cursor_matriz #(
  parameter int COLS         = 8,
  parameter int ROWS         = 8,
  parameter int X_W          = $clog2(COLS),
  parameter int Y_W          = $clog2(ROWS),
  parameter int HOME_X       = 0,
  parameter int HOME_Y       = 0,
  parameter int WRAP         = 0,
  parameter int SYNC_STAGES  = 2,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           arriba,
  input  logic           abajo,
  input  logic           derecha,
  input  logic           izquierda,
  input  logic           centrar,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic           moved,
  output logic           blocked
);

  if (COLS < 2 || ROWS < 2 || SYNC_STAGES < 2 || HOME_X < 0 || HOME_Y < 0 ||
      HOME_X >= COLS || HOME_Y >= ROWS || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("cursor_matriz: invalid parameter combination");
  end

  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_RIGHT, DIR_LEFT} dir_t;

  localparam logic [X_W-1:0] MAX_X  = X_W'(COLS - 1);
  localparam logic [Y_W-1:0] MAX_Y  = Y_W'(ROWS - 1);
  localparam logic [X_W-1:0] HOME_XV = X_W'(HOME_X);
  localparam logic [Y_W-1:0] HOME_YV = Y_W'(HOME_Y);

  logic [3:0]             raw;
  logic [3:0]             sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] primed;
  logic [3:0]             btn;
  logic [3:0]             hist;
  logic [3:0]             press;
  logic                   press_any;
  dir_t                   press_dir;

  assign raw = {izquierda, derecha, abajo, arriba};
  assign btn = sync_q[SYNC_STAGES-1];

  // History holds at 1 until the chain carries a post-reset sample, so a button held through reset is not a press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      primed <= '0;
      hist   <= '1;
    end else begin
      sync_q[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      primed <= {primed[SYNC_STAGES-2:0], 1'b1};
      hist   <= primed[SYNC_STAGES-1] ? btn : '1;
    end
  end

  always_comb begin
    press     = btn & ~hist;
    press_any = |press;
    if (press[1])      press_dir = DIR_DOWN;
    else if (press[0]) press_dir = DIR_UP;
    else if (press[2]) press_dir = DIR_RIGHT;
    else               press_dir = DIR_LEFT;
  end

  logic do_home;
  logic do_step;
  dir_t step_dir;

`ifdef CURSOR_REPEAT_EN
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  state_t           state, state_nxt;
  dir_t             track, track_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      track <= DIR_UP;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      track <= track_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A fresh press always restarts the hold timer on the new button, whatever was being tracked.
  always_comb begin
    state_nxt = state;
    track_nxt = track;
    cnt_nxt   = cnt;
    do_home   = 1'b0;
    do_step   = 1'b0;
    step_dir  = track;
    if (centrar) begin
      do_home   = 1'b1;
      state_nxt = IDLE;
    end else if (press_any) begin
      do_step   = 1'b1;
      step_dir  = press_dir;
      track_nxt = press_dir;
      state_nxt = HOLD;
      cnt_nxt   = CNT_W'(REPEAT_DELAY - 1);
    end else if (state != IDLE) begin
      if (!btn[track]) begin
        state_nxt = IDLE;
      end else if (cnt == '0) begin
        do_step   = 1'b1;
        state_nxt = REPEAT;
        cnt_nxt   = CNT_W'(REPEAT_RATE - 1);
      end else begin
        cnt_nxt = cnt - 1'b1;
      end
    end
  end
`else
  always_comb begin
    do_home  = centrar;
    do_step  = !centrar && press_any;
    step_dir = press_dir;
  end
`endif

  logic [X_W-1:0] step_x;
  logic [Y_W-1:0] step_y;
  logic           step_edge;

  always_comb begin
    step_x    = pos_x;
    step_y    = pos_y;
    step_edge = 1'b0;
    case (step_dir)
      DIR_UP: begin
        if (pos_y == MAX_Y) begin
          step_edge = 1'b1;
          step_y    = '0;
        end else begin
          step_y = pos_y + 1'b1;
        end
      end
      DIR_DOWN: begin
        if (pos_y == '0) begin
          step_edge = 1'b1;
          step_y    = MAX_Y;
        end else begin
          step_y = pos_y - 1'b1;
        end
      end
      DIR_RIGHT: begin
        if (pos_x == MAX_X) begin
          step_edge = 1'b1;
          step_x    = '0;
        end else begin
          step_x = pos_x + 1'b1;
        end
      end
      DIR_LEFT: begin
        if (pos_x == '0) begin
          step_edge = 1'b1;
          step_x    = MAX_X;
        end else begin
          step_x = pos_x - 1'b1;
        end
      end
      default: ;
    endcase
  end

  logic [X_W-1:0] next_x;
  logic [Y_W-1:0] next_y;
  logic           next_moved;
  logic           next_blocked;

  always_comb begin
    next_x       = pos_x;
    next_y       = pos_y;
    next_moved   = 1'b0;
    next_blocked = 1'b0;
    if (do_home) begin
      next_x     = HOME_XV;
      next_y     = HOME_YV;
      next_moved = (pos_x != HOME_XV) || (pos_y != HOME_YV);
    end else if (do_step) begin
      if (step_edge && (WRAP == 0)) begin
        next_blocked = 1'b1;
      end else begin
        next_x     = step_x;
        next_y     = step_y;
        next_moved = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_x   <= HOME_XV;
      pos_y   <= HOME_YV;
      moved   <= 1'b0;
      blocked <= 1'b0;
    end else begin
      pos_x   <= next_x;
      pos_y   <= next_y;
      moved   <= next_moved;
      blocked <= next_blocked;
    end
  end

endmodule

// File: tb/tb_cursor_matriz.sv
// Scoreboard bench for cursor_matriz: a saturating 5x6 instance (home 3,5) and a wrapping 5x6 instance (home 4,0).
// Expected strobes are queued with their due cycle and checked whenever moved/blocked fires.

module tb_cursor_matriz;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_RIGHT = 2;
  localparam int BTN_LEFT  = 3;

`ifdef CURSOR_REPEAT_EN
  localparam int Y_AFTER_HOLD = 5;
`else
  localparam int Y_AFTER_HOLD = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       arriba = 1'b0, abajo = 1'b0, derecha = 1'b0, izquierda = 1'b0, centrar = 1'b0;
  logic [2:0] pos_x, pos_y;
  logic       moved, blocked;
  logic       w_arriba = 1'b0, w_abajo = 1'b0, w_derecha = 1'b0, w_izquierda = 1'b0, w_centrar = 1'b0;
  logic [2:0] w_pos_x, w_pos_y;
  logic       w_moved, w_blocked;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    string      tag;
    int         at;
    logic [2:0] x;
    logic [2:0] y;
    logic       mv;
    logic       bk;
  } exp_t;

  exp_t sb[$];
  exp_t sbw[$];
  exp_t e_main;
  exp_t e_wrap;

  cursor_matriz #(
    .COLS(5), .ROWS(6), .HOME_X(3), .HOME_Y(5), .WRAP(0),
    .SYNC_STAGES(2), .REPEAT_DELAY(10), .REPEAT_RATE(3)
  ) dut (
    .clk(clk), .reset(reset),
    .arriba(arriba), .abajo(abajo), .derecha(derecha), .izquierda(izquierda),
    .centrar(centrar),
    .pos_x(pos_x), .pos_y(pos_y), .moved(moved), .blocked(blocked)
  );

  cursor_matriz #(
    .COLS(5), .ROWS(6), .HOME_X(4), .HOME_Y(0), .WRAP(1),
    .SYNC_STAGES(2), .REPEAT_DELAY(10), .REPEAT_RATE(3)
  ) dut_w (
    .clk(clk), .reset(reset),
    .arriba(w_arriba), .abajo(w_abajo), .derecha(w_derecha), .izquierda(w_izquierda),
    .centrar(w_centrar),
    .pos_x(w_pos_x), .pos_y(w_pos_y), .moved(w_moved), .blocked(w_blocked)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input int obs_at, input logic [2:0] ox, input logic [2:0] oy,
                             input logic om, input logic ob, input exp_t e);
    checks++;
    assert (obs_at == e.at && ox === e.x && oy === e.y && om === e.mv && ob === e.bk)
      else begin
        failures++;
        $error("[TB] FAIL %s: observed cycle=%0d pos=(%0d,%0d) moved=%b blocked=%b, expected cycle=%0d pos=(%0d,%0d) moved=%b blocked=%b",
               tag, obs_at, ox, oy, om, ob, e.at, e.x, e.y, e.mv, e.bk);
      end
  endtask

  task automatic checkNow(input bit w, input string tag, input int x, input int y);
    exp_t e;
    e.tag = tag;
    e.at  = cyc;
    e.x   = 3'(x);
    e.y   = 3'(y);
    e.mv  = 1'b0;
    e.bk  = 1'b0;
    if (w) checkOutput(tag, cyc, w_pos_x, w_pos_y, w_moved, w_blocked, e);
    else   checkOutput(tag, cyc, pos_x, pos_y, moved, blocked, e);
  endtask

  function automatic void expectAt(input bit w, input string tag, input int dt, input int x, input int y,
                                   input logic mv, input logic bk);
    exp_t e;
    e.tag = tag;
    e.at  = cyc + dt;
    e.x   = 3'(x);
    e.y   = 3'(y);
    e.mv  = mv;
    e.bk  = bk;
    if (w) sbw.push_back(e);
    else   sb.push_back(e);
  endfunction

  task automatic setBtn(input bit w, input int b, input logic v);
    if (w) begin
      case (b)
        BTN_UP:    w_arriba    = v;
        BTN_DOWN:  w_abajo     = v;
        BTN_RIGHT: w_derecha   = v;
        default:   w_izquierda = v;
      endcase
    end else begin
      case (b)
        BTN_UP:    arriba    = v;
        BTN_DOWN:  abajo     = v;
        BTN_RIGHT: derecha   = v;
        default:   izquierda = v;
      endcase
    end
  endtask

  // Called on a falling edge; leaves the button released long enough for the next press to be seen.
  task automatic applyStimulus(input bit w, input int b, input int hold);
    setBtn(w, b, 1'b1);
    repeat (hold) @(negedge clk);
    setBtn(w, b, 1'b0);
    repeat (4) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (moved || blocked) begin
      checks++;
      assert (sb.size() > 0)
        else begin
          failures++;
          $error("[TB] FAIL main_unexpected_strobe: observed moved=%b blocked=%b pos=(%0d,%0d) at cycle %0d, expected no strobe",
                 moved, blocked, pos_x, pos_y, cyc);
        end
      if (sb.size() > 0) begin
        e_main = sb.pop_front();
        checkOutput(e_main.tag, cyc, pos_x, pos_y, moved, blocked, e_main);
      end
    end
  end

  always @(negedge clk) begin
    if (w_moved || w_blocked) begin
      checks++;
      assert (sbw.size() > 0)
        else begin
          failures++;
          $error("[TB] FAIL wrap_unexpected_strobe: observed moved=%b blocked=%b pos=(%0d,%0d) at cycle %0d, expected no strobe",
                 w_moved, w_blocked, w_pos_x, w_pos_y, cyc);
        end
      if (sbw.size() > 0) begin
        e_wrap = sbw.pop_front();
        checkOutput(e_wrap.tag, cyc, w_pos_x, w_pos_y, w_moved, w_blocked, e_wrap);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    checkNow(1'b0, "reset_state", 3, 5);
    checkNow(1'b1, "w_reset_state", 4, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkNow(1'b0, "post_reset_idle", 3, 5);

    expectAt(1'b0, "right_move", 3, 4, 5, 1'b1, 1'b0);
    applyStimulus(1'b0, BTN_RIGHT, 4);
    expectAt(1'b0, "right_blocked", 3, 4, 5, 1'b0, 1'b1);
    applyStimulus(1'b0, BTN_RIGHT, 4);
    expectAt(1'b0, "up_blocked", 3, 4, 5, 1'b0, 1'b1);
    applyStimulus(1'b0, BTN_UP, 4);
    expectAt(1'b0, "down_move", 3, 4, 4, 1'b1, 1'b0);
    applyStimulus(1'b0, BTN_DOWN, 4);
    expectAt(1'b0, "left_move", 3, 3, 4, 1'b1, 1'b0);
    applyStimulus(1'b0, BTN_LEFT, 4);
    expectAt(1'b0, "left_move2", 3, 2, 4, 1'b1, 1'b0);
    applyStimulus(1'b0, BTN_LEFT, 4);
    expectAt(1'b0, "down_to_3", 3, 2, 3, 1'b1, 1'b0);
    applyStimulus(1'b0, BTN_DOWN, 4);
    expectAt(1'b0, "down_to_2", 3, 2, 2, 1'b1, 1'b0);
    applyStimulus(1'b0, BTN_DOWN, 4);

    // Coincident presses: abajo wins, derecha stays held and must never act.
    expectAt(1'b0, "down_beats_right", 3, 2, 1, 1'b1, 1'b0);
    setBtn(1'b0, BTN_DOWN, 1'b1);
    setBtn(1'b0, BTN_RIGHT, 1'b1);
    repeat (4) @(negedge clk);
    setBtn(1'b0, BTN_DOWN, 1'b0);
    repeat (8) @(negedge clk);
    setBtn(1'b0, BTN_RIGHT, 1'b0);
    repeat (4) @(negedge clk);
    checkNow(1'b0, "right_discarded", 2, 1);

    expectAt(1'b0, "centre_home", 1, 3, 5, 1'b1, 1'b0);
    centrar = 1'b1;
    repeat (3) @(negedge clk);
    centrar = 1'b0;
    repeat (2) @(negedge clk);
    checkNow(1'b0, "centre_level_quiet", 3, 5);

    reset = 1'b0;
    setBtn(1'b0, BTN_LEFT, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    checkNow(1'b0, "held_through_reset", 3, 5);
    setBtn(1'b0, BTN_LEFT, 1'b0);
    repeat (4) @(negedge clk);
    expectAt(1'b0, "left_after_release", 3, 2, 5, 1'b1, 1'b0);
    applyStimulus(1'b0, BTN_LEFT, 4);

    for (int i = 4; i >= 0; i--) begin
      expectAt(1'b0, "down_walk", 3, 2, i, 1'b1, 1'b0);
      applyStimulus(1'b0, BTN_DOWN, 4);
    end

`ifdef CURSOR_REPEAT_EN
    expectAt(1'b0, "up_press", 3, 2, 1, 1'b1, 1'b0);
    expectAt(1'b0, "up_repeat1", 13, 2, 2, 1'b1, 1'b0);
    expectAt(1'b0, "up_repeat2", 16, 2, 3, 1'b1, 1'b0);
    expectAt(1'b0, "up_repeat3", 19, 2, 4, 1'b1, 1'b0);
    expectAt(1'b0, "up_repeat4", 22, 2, 5, 1'b1, 1'b0);
`else
    expectAt(1'b0, "up_press", 3, 2, 1, 1'b1, 1'b0);
`endif
    applyStimulus(1'b0, BTN_UP, 20);
    checkNow(1'b0, "up_hold_final", 2, Y_AFTER_HOLD);

    expectAt(1'b0, "left_press", 3, 1, Y_AFTER_HOLD, 1'b1, 1'b0);
`ifdef CURSOR_REPEAT_EN
    expectAt(1'b0, "left_repeat", 13, 0, Y_AFTER_HOLD, 1'b1, 1'b0);
    expectAt(1'b0, "left_repeat_blocked", 16, 0, Y_AFTER_HOLD, 1'b0, 1'b1);
`endif
    setBtn(1'b0, BTN_LEFT, 1'b1);
    repeat (17) @(negedge clk);
    reset = 1'b0;
    #1;
    checkNow(1'b0, "mid_repeat_reset", 3, 5);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    setBtn(1'b0, BTN_LEFT, 1'b0);
    repeat (4) @(negedge clk);
    checkNow(1'b0, "after_mid_reset", 3, 5);

    expectAt(1'b0, "left_hold_press", 3, 2, 5, 1'b1, 1'b0);
    expectAt(1'b0, "centre_in_hold", 9, 3, 5, 1'b1, 1'b0);
    setBtn(1'b0, BTN_LEFT, 1'b1);
    repeat (8) @(negedge clk);
    centrar = 1'b1;
    @(negedge clk);
    centrar = 1'b0;
    repeat (20) @(negedge clk);
    setBtn(1'b0, BTN_LEFT, 1'b0);
    repeat (4) @(negedge clk);
    checkNow(1'b0, "centre_stops_hold", 3, 5);

    expectAt(1'b1, "w_right_wrap", 3, 0, 0, 1'b1, 1'b0);
    applyStimulus(1'b1, BTN_RIGHT, 4);
    expectAt(1'b1, "w_left_wrap", 3, 4, 0, 1'b1, 1'b0);
    applyStimulus(1'b1, BTN_LEFT, 4);
    expectAt(1'b1, "w_down_wrap", 3, 4, 5, 1'b1, 1'b0);
    applyStimulus(1'b1, BTN_DOWN, 4);
    expectAt(1'b1, "w_up_wrap", 3, 4, 0, 1'b1, 1'b0);
    applyStimulus(1'b1, BTN_UP, 4);
    checkNow(1'b1, "w_final", 4, 0);

    repeat (5) @(negedge clk);
    checks++;
    assert (sb.size() == 0)
      else begin
        failures++;
        $error("[TB] FAIL main_missing_strobe: observed %0d pending (next %s due cycle %0d), expected 0",
               sb.size(), sb[0].tag, sb[0].at);
      end
    checks++;
    assert (sbw.size() == 0)
      else begin
        failures++;
        $error("[TB] FAIL wrap_missing_strobe: observed %0d pending (next %s due cycle %0d), expected 0",
               sbw.size(), sbw[0].tag, sbw[0].at);
      end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
